apb_master_bridge: RTL
======================

// Module: apb_master_bridge
// PURPOSE
//  APB initiator: converts a single-outstanding cmd valid/ready request into an APB SETUP/ACCESS
//  transfer and returns the result on a rsp valid/ready channel. It is the requester for the
//  peripherals behind apb_if. It honours PREADY wait states and aborts hung transfers via a timeout.
// PARAMETERS
//  ADDR_W          8    paddr / cmd_addr width
//  DATA_W          8    pwdata / prdata / rsp_rdata width
//  TIMEOUT_CYCLES  16   max ACCESS cycles with pready=0 before abort; 0 = never time out
// PORTS
//  pclk        in   1       clock, all state on posedge
//  prst        in   1       asynchronous active-high reset
//  cmd_valid   in   1       request valid
//  cmd_ready   out  1       bridge can accept a request
//  cmd_write   in   1       1=write, 0=read
//  cmd_addr    in   ADDR_W  target address
//  cmd_wdata   in   DATA_W  write data (ignored for reads)
//  rsp_valid   out  1       response valid, held until rsp_ready
//  rsp_ready   in   1       response consumer ready
//  rsp_rdata   out  DATA_W  read data (0 for writes/aborts)
//  rsp_err     out  1       pslverr seen or timeout
//  rsp_timeout out  1       transfer aborted by timeout
//  psel        out  1       APB select
//  penable     out  1       APB enable
//  pwrite      out  1       APB direction
//  paddr       out  ADDR_W  APB address
//  pwdata      out  DATA_W  APB write data
//  prdata      in   DATA_W  APB read data
//  pready      in   1       APB ready
//  pslverr     in   1       APB slave error
// BEHAVIOUR
//  - Reset (async, immediate): state=IDLE; every output 0 except cmd_ready, which is 1 after
//    release. A transfer in flight is dropped and no response is issued.
//  - All APB outputs and rsp_* come from registers; nothing is combinational from inputs.
//  - FSM states: IDLE, SETUP, ACCESS, RESP.
//  - IDLE: cmd_ready=1. On cmd_valid, register addr/write/wdata -> SETUP.
//  - SETUP, one cycle: psel=1, penable=0. -> ACCESS.
//  - ACCESS: psel=1, penable=1. paddr/pwrite/pwdata stay stable every cycle.
//    - pready=1: latch prdata (reads; 0 for writes) and pslverr into rsp_rdata/rsp_err;
//      set rsp_valid; drop psel/penable next cycle -> RESP. Latency: cmd accept -> rsp_valid = 3 cycles.
//    - pready=0: wait counter += 1. When TIMEOUT_CYCLES!=0 and the count reaches TIMEOUT_CYCLES:
//      abort with psel=penable=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0 -> RESP.
//  - RESP: rsp_valid=1 with payload held stable until rsp_ready.
//    - cmd_ready = rsp_ready, so a new cmd in the same cycle as rsp_ready goes straight to SETUP.
//    - This gives a back-to-back transfer period of 3 cycles, with penable low between transfers.
//    - On rsp_ready with no cmd -> IDLE; rsp_* clear to 0.
//  - The wait counter clears on entry to SETUP. It saturates and is ceil(log2(TIMEOUT_CYCLES+1)) bits wide.
//  - pslverr is sampled only on the completing ACCESS cycle; it is ignored elsewhere.
//  - psel is never high outside SETUP/ACCESS. penable is never high without psel.
//  - A timeout may violate slave-side A3 stability. This is deliberate; the bench disables A3/A4 for timeout tests.
// STRUCTURE
//  - apb_pkg:
//    - typedef enum logic [1:0] {APB_IDLE, APB_SETUP, APB_ACCESS, APB_RESP} apb_state_e
//    - localparams APB_ADDR_W=8, APB_DATA_W=8
//    - typedef struct apb_cmd_t {write, addr, wdata}
//  - Sub-module apb_wait_timer: clear/inc/expire counter with TIMEOUT_CYCLES param; 0 disables.
//  - Top: FSM plus command/response registers.
// TESTING (bench binds apb_if assertions on the APB side)
//  1. Write 0x3C->0x10, zero-wait slave:
//     psel one cycle before penable, paddr=0x10, pwdata=0x3C;
//     rsp_valid 3 cycles after accept, rsp_err=0.
//  2. Read 0x22, slave holds pready=0 for 4 ACCESS cycles then prdata=0xA5:
//     paddr stable for all 5 ACCESS cycles; rsp_rdata=0xA5, rsp_timeout=0.
//  3. Write 0xFF with pslverr=1 at completion: rsp_err=1, rsp_timeout=0, rsp_rdata=0.
//  4. Read, pready stuck low, TIMEOUT_CYCLES=16: abort after 16 ACCESS cycles;
//     psel=0 next cycle; rsp_err=1, rsp_timeout=1, rsp_rdata=0.
//  5. Three back-to-back writes (0x01,0x02,0x03) with rsp_ready=1 held:
//     new psel rise every 3 cycles, penable low between transfers, 3 responses in order.
//  6. prst pulse during ACCESS: psel/penable/rsp_valid go 0 asynchronously;
//     after release cmd_ready=1 and no stale response appears.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge.
//   apb_state_e : bridge FSM states
//   apb_cmd_t   : one captured request (direction, address, write data)
//   timer_width : width of a saturating wait counter that must reach `cycles`
package apb_pkg;

  localparam int APB_ADDR_W = 8;
  localparam int APB_DATA_W = 8;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_SETUP,
    APB_ACCESS,
    APB_RESP
  } apb_state_e;

  typedef struct packed {
    logic                  write;
    logic [APB_ADDR_W-1:0] addr;
    logic [APB_DATA_W-1:0] wdata;
  } apb_cmd_t;

  // A zero limit still needs one bit so the counter has a legal width.
  function automatic int timer_width(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Counts ACCESS cycles spent waiting on pready and flags the last permitted one.
//   clk    : clock
//   rst    : asynchronous active-high reset
//   clear  : restart the count (new transfer)
//   inc    : one more wait cycle observed
//   expire : the count already holds TIMEOUT_CYCLES-1, so one more wait
//            cycle reaches the limit; never asserted when TIMEOUT_CYCLES=0
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic inc,
  output logic expire
);

  localparam int CNT_W = timer_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_W'(1);
    end
  end

  // Depends only on the registered count, so the FSM can combine it with
  // pready without forming a combinational loop through inc.
  assign expire = (TIMEOUT_CYCLES != 0) && (count == CNT_LAST);

endmodule

// File: rtl/apb_master_bridge.sv
// APB initiator: turns one cmd valid/ready request into an APB SETUP/ACCESS
// transfer and returns the outcome on a rsp valid/ready channel.
//   pclk, prst                : clock, asynchronous active-high reset
//   cmd_valid/ready/write/addr/wdata : request channel (single outstanding)
//   rsp_valid/ready/rdata/err/timeout : response channel, held until rsp_ready
//   psel/penable/pwrite/paddr/pwdata  : APB request outputs (all registered)
//   prdata/pready/pslverr             : APB completion inputs
//
// state      | meaning
// APB_IDLE   | waiting for a request, cmd_ready=1
// APB_SETUP  | psel=1, penable=0 for exactly one cycle
// APB_ACCESS | psel=1, penable=1 until pready or timeout
// APB_RESP   | response held; cmd_ready follows rsp_ready
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W         = APB_ADDR_W,
  parameter int DATA_W         = APB_DATA_W,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclk,
  input  logic              prst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_e        state, state_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic              accept;
  logic              timer_clear, timer_inc, timer_expire;

  // Accepting in RESP while the response is consumed gives the 3-cycle
  // back-to-back period; held low during reset so nothing is taken then.
  assign cmd_ready = !prst && ((state == APB_IDLE) || ((state == APB_RESP) && rsp_ready));
  assign accept    = cmd_valid && cmd_ready;

  apb_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk   (pclk),
    .rst   (prst),
    .clear (timer_clear),
    .inc   (timer_inc),
    .expire(timer_expire)
  );

  always_comb begin
    state_d       = state;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    timer_clear   = 1'b0;
    timer_inc     = 1'b0;

    unique case (state)
      APB_IDLE: state_d = APB_IDLE;
      APB_SETUP: state_d = APB_ACCESS;
      APB_ACCESS: begin
        if (pready) begin
          state_d       = APB_RESP;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = pwrite ? '0 : prdata;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
        end else begin
          timer_inc = 1'b1;
          if (timer_expire) begin
            state_d       = APB_RESP;
            rsp_valid_d   = 1'b1;
            rsp_rdata_d   = '0;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b1;
          end
        end
      end
      APB_RESP: begin
        if (rsp_ready) begin
          state_d       = APB_IDLE;
          rsp_valid_d   = 1'b0;
          rsp_rdata_d   = '0;
          rsp_err_d     = 1'b0;
          rsp_timeout_d = 1'b0;
        end
      end
      default: state_d = APB_IDLE;
    endcase

    if (accept) begin
      state_d     = APB_SETUP;
      pwrite_d    = cmd_write;
      paddr_d     = cmd_addr;
      pwdata_d    = cmd_wdata;
      timer_clear = 1'b1;
    end

    // Bus strobes are decoded from the next state so they leave a flop.
    psel_d    = (state_d == APB_SETUP) || (state_d == APB_ACCESS);
    penable_d = (state_d == APB_ACCESS);
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state       <= APB_IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
    end
  end

endmodule
